doorlock_ctrl: RTL
==================

// Module: doorlock_ctrl
// PURPOSE
//  Parametrised keypad door-lock controller. Collects a CODE_LEN-digit passcode
//  between ps_start and ps_end, compares it to a stored code, and holds unlock
//  for OPEN_CYCLES. Adds an entry timeout, a failed-attempt counter and a lockout.
//  Sits between the keypad debouncer/decoder and the lock actuator and display.
// PARAMETERS
//  CODE_LEN       4       digits per passcode (>=1)
//  DIGIT_W        4       bits per digit
//  DEFAULT_CODE   16'h1234  stored code after reset (CODE_LEN*DIGIT_W bits)
//  OPEN_CYCLES    5000    cycles unlock is held high
//  ENTRY_TIMEOUT  50000   idle cycles in ENTRY before abort
//  MAX_FAIL       3       consecutive failures that trigger LOCKOUT (>=1)
//  LOCKOUT_CYCLES 100000  cycles spent in LOCKOUT
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  rst        in   1        synchronous reset, active-high
//  ps_start   in   1        1-cycle pulse: begin entry (accepted only in IDLE)
//  key_valid  in   1        1-cycle pulse: key_digit is valid
//  key_digit  in   DIGIT_W  digit value
//  ps_end     in   1        1-cycle pulse: submit the entry (accepted only in ENTRY)
//  state_out  out  3        current state encoding
//  unlock     out  1        lock actuator drive, registered
//  err        out  1        1-cycle pulse on a rejected or aborted entry
//  digit_cnt  out  clog2(CODE_LEN+1)  digits captured so far
//  fail_cnt   out  clog2(MAX_FAIL+1)  consecutive failures
// BEHAVIOUR
//  Reset: state=IDLE(0), unlock=0, err=0, digit_cnt=0, fail_cnt=0, entry reg=0,
//   stored code=DEFAULT_CODE. A reset mid-operation aborts at once; no err pulse.
//  States: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, LOCKOUT=4. Other codes -> IDLE.
//  IDLE: ps_start -> ENTRY and clear entry reg, digit_cnt and the timeout counter.
//  ENTRY: key_valid shifts the digit in (MSB digit first) and increments digit_cnt.
//   digit_cnt saturates at CODE_LEN. A further digit sets an overflow flag and
//   forces a failure at CHECK. Every key restarts the timeout.
//   ps_end -> CHECK. If key_valid and ps_end arrive together, the key is captured first.
//   ENTRY_TIMEOUT cycles with no key -> IDLE, err pulse, fail_cnt unchanged.
//  CHECK (exactly 1 cycle): match = (entry==stored) && digit_cnt==CODE_LEN && !ovf.
//   If match: -> OPEN and fail_cnt=0.
//   Else if fail_cnt+1==MAX_FAIL: -> LOCKOUT, err pulse, fail_cnt=MAX_FAIL.
//   Else: -> IDLE, err pulse, fail_cnt+1.
//  OPEN: unlock=1 for exactly OPEN_CYCLES cycles, then -> IDLE, unlock=0.
//  LOCKOUT: all inputs ignored for LOCKOUT_CYCLES cycles, then -> IDLE, fail_cnt=0.
//  Latency: ps_end in cycle N -> state CHECK in N+1 -> OPEN and unlock=1 in N+2.
//  Inputs ignored outside their state: ps_start outside IDLE, keys and ps_end
//   outside ENTRY.
//  Counters are sized clog2(max+1) and never wrap.
// CONFIGURATION
//  DOORLOCK_CODE_SET_EN defined: ports set_code(in,1) and new_code(in,
//   CODE_LEN*DIGIT_W) exist. A set_code pulse while in OPEN loads new_code into
//   the stored code on the next edge. set_code in any other state is ignored.
//   Reset restores DEFAULT_CODE.
//  Undefined: neither port exists and the stored code is the constant DEFAULT_CODE.
// STRUCTURE
//  doorlock_pkg holds: state localparams (IDLE..LOCKOUT), STATE_W=3, and the
//   clog2 function.
//  One sub-module, doorlock_timer: a loadable down-counter with
//   load/val/expire. It is reused for entry timeout, OPEN and LOCKOUT; only one
//   of these is active at a time.
//  FSM and code register stay in doorlock_ctrl.
// TESTING (bench params: OPEN_CYCLES=8, ENTRY_TIMEOUT=20, MAX_FAIL=3,
//  LOCKOUT_CYCLES=30)
//  1. rst, ps_start, keys 1,2,3,4, ps_end -> CHECK, then OPEN; unlock=1 for 8
//     cycles; IDLE; fail_cnt=0.
//  2. Three entries of 1,2,3,5 -> err pulses; fail_cnt 1, 2; 3rd -> LOCKOUT;
//     ps_start ignored for 30 cycles; then IDLE, fail_cnt=0.
//  3. Keys 1,2,3,4,5 (overflow) or 1,2,3 (short), then ps_end -> rejected with err;
//     digit_cnt shows 4 or 3.
//  4. ps_start, key 1, then 20 quiet cycles -> IDLE with err; fail_cnt unchanged;
//     key 4 sent with ps_end in the same cycle after 1,2,3 -> OPEN.
//  5. rst asserted during OPEN and during LOCKOUT -> next cycle IDLE, unlock=0,
//     counters=0.
//  6. With DOORLOCK_CODE_SET_EN: in OPEN, set_code with new_code=16'h9876 ->
//     1234 is rejected and 9876 opens; set_code in IDLE has no effect.

Source files
------------

// File: rtl/doorlock_pkg.sv
// -----------------------------------------------------------------------------
// doorlock_pkg
// Shared definitions for the keypad door-lock controller:
//   STATE_W  - width of the state encoding presented on state_out
//   state_t  - FSM state encoding (IDLE=0, ENTRY=1, CHECK=2, OPEN=3, LOCKOUT=4)
//   clog2    - ceiling log2, used to size counters as clog2(max+1)
// -----------------------------------------------------------------------------
package doorlock_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    // Ceiling log2 of value (value >= 1); clog2(1) = 0.
    function automatic int clog2(input int unsigned value);
        int unsigned v;
        int          r;
        v = value - 32'd1;
        r = 0;
        while (v > 32'd0) begin
            r = r + 1;
            v = v >> 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/doorlock_if.sv
// -----------------------------------------------------------------------------
// doorlock_if
// Bundles the keypad-side inputs and the status/actuator outputs of
// doorlock_ctrl.
//   master : keypad/decoder side, drives ps_start, key_valid, key_digit, ps_end
//   slave  : doorlock_ctrl side, drives state_out, unlock, err, digit_cnt, fail_cnt
// With DOORLOCK_CODE_SET_EN defined, set_code and new_code are added (master
// drives them).
// -----------------------------------------------------------------------------
interface doorlock_if
    import doorlock_pkg::*;
#(
    parameter int CODE_LEN = 4,
    parameter int DIGIT_W  = 4,
    parameter int MAX_FAIL = 3
);

    logic                              ps_start;
    logic                              key_valid;
    logic [DIGIT_W-1:0]                key_digit;
    logic                              ps_end;
`ifdef DOORLOCK_CODE_SET_EN
    logic                              set_code;
    logic [CODE_LEN*DIGIT_W-1:0]       new_code;
`endif
    logic [STATE_W-1:0]                state_out;
    logic                              unlock;
    logic                              err;
    logic [clog2(CODE_LEN+1)-1:0]      digit_cnt;
    logic [clog2(MAX_FAIL+1)-1:0]      fail_cnt;

    modport master (
        output ps_start, key_valid, key_digit, ps_end,
`ifdef DOORLOCK_CODE_SET_EN
        output set_code, new_code,
`endif
        input  state_out, unlock, err, digit_cnt, fail_cnt
    );

    modport slave (
        input  ps_start, key_valid, key_digit, ps_end,
`ifdef DOORLOCK_CODE_SET_EN
        input  set_code, new_code,
`endif
        output state_out, unlock, err, digit_cnt, fail_cnt
    );

endinterface

// File: rtl/doorlock_timer.sv
// -----------------------------------------------------------------------------
// doorlock_timer
// Loadable down-counter shared by the entry timeout, OPEN hold and LOCKOUT hold.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : load val into the counter on the next edge (wins over counting)
//   val      : load value; loading N gives N+1 cycles until expire is acted upon
//   expire   : high while the counter sits at zero
// The counter stops at zero and never wraps.
// -----------------------------------------------------------------------------
module doorlock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] val,
    output logic         expire
);

    logic [W-1:0] cnt_r;

    // Count down towards zero, reload on request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == '0);

endmodule

// File: rtl/doorlock_ctrl.sv
// -----------------------------------------------------------------------------
// doorlock_ctrl
// Keypad door-lock controller. Collects a CODE_LEN-digit passcode between
// ps_start and ps_end, compares it against the stored code and holds unlock
// for OPEN_CYCLES. Aborts an idle entry after ENTRY_TIMEOUT quiet cycles and
// enters LOCKOUT for LOCKOUT_CYCLES after MAX_FAIL consecutive failures.
// Ports:
//   clk  : system clock (posedge)
//   rst  : synchronous active-high reset
//   bus  : doorlock_if.slave - ps_start, key_valid, key_digit, ps_end in;
//          state_out, unlock, err, digit_cnt, fail_cnt out (all registered)
// Configuration macro DOORLOCK_CODE_SET_EN: when defined, a set_code pulse
// while OPEN loads new_code as the stored code; otherwise the stored code is
// the constant DEFAULT_CODE.
// -----------------------------------------------------------------------------
module doorlock_ctrl
    import doorlock_pkg::*;
#(
    parameter int                           CODE_LEN       = 4,
    parameter int                           DIGIT_W        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE   = 16'h1234,
    parameter int                           OPEN_CYCLES    = 5000,
    parameter int                           ENTRY_TIMEOUT  = 50000,
    parameter int                           MAX_FAIL       = 3,
    parameter int                           LOCKOUT_CYCLES = 100000
) (
    input logic       clk,
    input logic       rst,
    doorlock_if.slave bus
);

    localparam int CODE_W  = CODE_LEN * DIGIT_W;
    localparam int CNT_W   = clog2(CODE_LEN + 1);
    localparam int FAIL_W  = clog2(MAX_FAIL + 1);
    localparam int TMR_MAX = (OPEN_CYCLES > ENTRY_TIMEOUT) ?
                             ((OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES) :
                             ((ENTRY_TIMEOUT > LOCKOUT_CYCLES) ? ENTRY_TIMEOUT : LOCKOUT_CYCLES);
    localparam int TMR_W   = clog2(TMR_MAX + 1);

    // A state lasts load+1 cycles, so each hold is loaded with its length minus one.
    localparam logic [TMR_W-1:0] ENTRY_LOAD   = TMR_W'(ENTRY_TIMEOUT - 32'sd1);
    localparam logic [TMR_W-1:0] OPEN_LOAD    = TMR_W'(OPEN_CYCLES - 32'sd1);
    localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 32'sd1);

    state_t              state_r;
    logic                unlock_r;
    logic                err_r;
    logic [CNT_W-1:0]    digit_cnt_r;
    logic [FAIL_W-1:0]   fail_cnt_r;
    logic [CODE_W-1:0]   entry_r;
    logic                ovf_r;
    logic [CODE_W-1:0]   stored_code_s;
    logic                match_s;
    logic [FAIL_W-1:0]   fail_next_s;
    logic                tmr_load_s;
    logic [TMR_W-1:0]    tmr_val_s;
    logic                tmr_expire_s;

`ifdef DOORLOCK_CODE_SET_EN
    logic [CODE_W-1:0]   code_r;

    // Stored code: reloadable only while the door is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_r <= DEFAULT_CODE;
        end else if ((state_r == OPEN) && bus.set_code) begin
            code_r <= bus.new_code;
        end else begin
            code_r <= code_r;
        end
    end

    assign stored_code_s = code_r;
`else
    assign stored_code_s = DEFAULT_CODE;
`endif

    assign match_s     = (entry_r == stored_code_s) &&
                         (digit_cnt_r == CNT_W'(CODE_LEN)) && !ovf_r;
    // Outside LOCKOUT fail_cnt stays below MAX_FAIL, so +1 cannot wrap.
    assign fail_next_s = fail_cnt_r + FAIL_W'(1);

    // Select which hold the shared timer runs for on each state entry or key.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        case (state_r)
            IDLE: begin
                if (bus.ps_start) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = ENTRY_LOAD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ENTRY: begin
                if (bus.key_valid) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = ENTRY_LOAD;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            CHECK: begin
                tmr_load_s = 1'b1;
                if (match_s) begin
                    tmr_val_s = OPEN_LOAD;
                end else begin
                    tmr_val_s = LOCKOUT_LOAD;
                end
            end
            default: begin
                tmr_load_s = 1'b0;
            end
        endcase
    end

    doorlock_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load_s),
        .val    (tmr_val_s),
        .expire (tmr_expire_s)
    );

    // Main FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            unlock_r    <= 1'b0;
            err_r       <= 1'b0;
            digit_cnt_r <= '0;
            fail_cnt_r  <= '0;
            entry_r     <= '0;
            ovf_r       <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.ps_start) begin
                        state_r     <= ENTRY;
                        entry_r     <= '0;
                        digit_cnt_r <= '0;
                        ovf_r       <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ENTRY: begin
                    // Key is captured even when ps_end arrives in the same cycle.
                    if (bus.key_valid) begin
                        entry_r <= CODE_W'({entry_r, bus.key_digit});
                        if (digit_cnt_r == CNT_W'(CODE_LEN)) begin
                            ovf_r <= 1'b1;
                        end else begin
                            digit_cnt_r <= digit_cnt_r + CNT_W'(1);
                        end
                    end else begin
                        entry_r <= entry_r;
                    end
                    if (bus.ps_end) begin
                        state_r <= CHECK;
                    end else if (!bus.key_valid && tmr_expire_s) begin
                        state_r <= IDLE;
                        err_r   <= 1'b1;
                    end else begin
                        state_r <= ENTRY;
                    end
                end
                CHECK: begin
                    if (match_s) begin
                        state_r    <= OPEN;
                        unlock_r   <= 1'b1;
                        fail_cnt_r <= '0;
                    end else if (fail_next_s == FAIL_W'(MAX_FAIL)) begin
                        state_r    <= LOCKOUT;
                        err_r      <= 1'b1;
                        fail_cnt_r <= FAIL_W'(MAX_FAIL);
                    end else begin
                        state_r    <= IDLE;
                        err_r      <= 1'b1;
                        fail_cnt_r <= fail_next_s;
                    end
                end
                OPEN: begin
                    if (tmr_expire_s) begin
                        state_r  <= IDLE;
                        unlock_r <= 1'b0;
                    end else begin
                        state_r  <= OPEN;
                        unlock_r <= 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (tmr_expire_s) begin
                        state_r    <= IDLE;
                        fail_cnt_r <= '0;
                    end else begin
                        state_r <= LOCKOUT;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    unlock_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state_out = state_r;
    assign bus.unlock    = unlock_r;
    assign bus.err       = err_r;
    assign bus.digit_cnt = digit_cnt_r;
    assign bus.fail_cnt  = fail_cnt_r;

endmodule
